hazard_pipe_ctrl: RTL

Consumer side of the decoded-control interface in the five-stage pipelined RISC-V core. Takes the Decode-stage control bundle and carries it through the ID/EX, EX/MEM and MEM/WB control registers. Returns `branch_E`/`jump_E` to the decoder, which computes `pcsrc_E` from them and feeds it back here. Also detects data and control hazards and drives the stall, flush and forwarding selects for the datapath.

---
 rtl/hazard_pipe_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/hazard_pipe_ctrl.sv
// hazard_pipe_ctrl
//
// Carries the decoded control bundle of a five-stage RISC-V pipeline through the
// ID/EX, EX/MEM and MEM/WB control registers, and derives the hazard controls
// (stall, flush) and operand-forwarding selects for the datapath.
//
// Build option:
//   HAZARD_FORWARDING_EN  defined   -> full forwarding, only load-use stalls.
//                         undefined -> no forwarding; any E/M producer match stalls D.
//
// Ports:
//   clk, reset                 rising-edge clock, asynchronous active-high reset
//   *_D                        decoded control and register fields of the Decode instruction
//   pcsrc_E                    taken branch/jump resolved in Execute
//   branch_E, jump_E, alusrc_E, alucontrol_E   Execute-stage control
//   memwrite_M                 Memory-stage store enable
//   resultsrc_W, regwrite_W, rd_W              Writeback control
//   stall_F, stall_D           hold PC and IF/ID
//   flush_D, flush_E           clear IF/ID, bubble ID/EX
//   forward_a_E, forward_b_E   operand select: 00 regfile, 10 Memory ALU result, 01 Writeback
module hazard_pipe_ctrl #(
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              regwrite_D,
  input  logic              memwrite_D,
  input  logic              jump_D,
  input  logic              branch_D,
  input  logic              alusrc_D,
  input  logic [1:0]        resultsrc_D,
  input  logic [2:0]        alucontrol_D,
  input  logic [REG_AW-1:0] rs1_D,
  input  logic [REG_AW-1:0] rs2_D,
  input  logic [REG_AW-1:0] rd_D,
  input  logic              pcsrc_E,
  output logic              branch_E,
  output logic              jump_E,
  output logic              alusrc_E,
  output logic [2:0]        alucontrol_E,
  output logic              memwrite_M,
  output logic [1:0]        resultsrc_W,
  output logic              regwrite_W,
  output logic [REG_AW-1:0] rd_W,
  output logic              stall_F,
  output logic              stall_D,
  output logic              flush_D,
  output logic              flush_E,
  output logic [1:0]        forward_a_E,
  output logic [1:0]        forward_b_E
);

  typedef struct packed {
    logic              regwrite;
    logic [1:0]        resultsrc;
    logic              memwrite;
    logic              jump;
    logic              branch;
    logic [2:0]        alucontrol;
    logic              alusrc;
    logic [REG_AW-1:0] rd;
  } ctrl_e_t;

  typedef struct packed {
    logic              regwrite;
    logic [1:0]        resultsrc;
    logic              memwrite;
    logic [REG_AW-1:0] rd;
  } ctrl_m_t;

  typedef struct packed {
    logic              regwrite;
    logic [1:0]        resultsrc;
    logic [REG_AW-1:0] rd;
  } ctrl_w_t;

  ctrl_e_t r_e;
  ctrl_e_t w_e_d;
  ctrl_m_t r_m;
  ctrl_w_t r_w;

  logic w_data_stall;
  logic w_flush_E;

  always_comb begin
    w_e_d            = '0;
    w_e_d.regwrite   = regwrite_D;
    w_e_d.resultsrc  = resultsrc_D;
    w_e_d.memwrite   = memwrite_D;
    w_e_d.jump       = jump_D;
    w_e_d.branch     = branch_D;
    w_e_d.alucontrol = alucontrol_D;
    w_e_d.alusrc     = alusrc_D;
    w_e_d.rd         = rd_D;
  end

  // M and W always advance; only E can be replaced by a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_e <= '0;
      r_m <= '0;
      r_w <= '0;
    end else begin
      r_e           <= w_flush_E ? '0 : w_e_d;
      r_m.regwrite  <= r_e.regwrite;
      r_m.resultsrc <= r_e.resultsrc;
      r_m.memwrite  <= r_e.memwrite;
      r_m.rd        <= r_e.rd;
      r_w.regwrite  <= r_m.regwrite;
      r_w.resultsrc <= r_m.resultsrc;
      r_w.rd        <= r_m.rd;
    end
  end

`ifdef HAZARD_FORWARDING_EN
  // Source-register tags travel with E only to steer the forwarding muxes.
  logic [REG_AW-1:0] r_rs1_E;
  logic [REG_AW-1:0] r_rs2_E;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rs1_E <= '0;
      r_rs2_E <= '0;
    end else if (w_flush_E) begin
      r_rs1_E <= '0;
      r_rs2_E <= '0;
    end else begin
      r_rs1_E <= rs1_D;
      r_rs2_E <= rs2_D;
    end
  end

  // Memory result is younger than Writeback, so it wins.
  always_comb begin
    forward_a_E = 2'b00;
    if (r_m.regwrite && (r_m.rd != '0) && (r_m.rd == r_rs1_E)) begin
      forward_a_E = 2'b10;
    end else if (r_w.regwrite && (r_w.rd != '0) && (r_w.rd == r_rs1_E)) begin
      forward_a_E = 2'b01;
    end
  end

  always_comb begin
    forward_b_E = 2'b00;
    if (r_m.regwrite && (r_m.rd != '0) && (r_m.rd == r_rs2_E)) begin
      forward_b_E = 2'b10;
    end else if (r_w.regwrite && (r_w.rd != '0) && (r_w.rd == r_rs2_E)) begin
      forward_b_E = 2'b01;
    end
  end

  // Load data is not available until W, so a dependent instruction waits one slot.
  assign w_data_stall = (r_e.resultsrc == 2'b01) && (r_e.rd != '0) &&
                        ((r_e.rd == rs1_D) || (r_e.rd == rs2_D));
`else
  logic w_hit_rs1;
  logic w_hit_rs2;

  assign forward_a_E = 2'b00;
  assign forward_b_E = 2'b00;

  // Without bypass paths, wait until the producer has left M; a W producer is
  // fine because the register file writes on the falling edge.
  assign w_hit_rs1 = (rs1_D != '0) &&
                     ((r_e.regwrite && (r_e.rd == rs1_D)) ||
                      (r_m.regwrite && (r_m.rd == rs1_D)));
  assign w_hit_rs2 = (rs2_D != '0) &&
                     ((r_e.regwrite && (r_e.rd == rs2_D)) ||
                      (r_m.regwrite && (r_m.rd == rs2_D)));
  assign w_data_stall = w_hit_rs1 || w_hit_rs2;
`endif

  // A taken branch discards D anyway, so stalling would only delay the target fetch.
  assign w_flush_E = w_data_stall || pcsrc_E;
  assign stall_F   = w_data_stall && !pcsrc_E;
  assign stall_D   = w_data_stall && !pcsrc_E;
  assign flush_D   = pcsrc_E;
  assign flush_E   = w_flush_E;

  assign branch_E     = r_e.branch;
  assign jump_E       = r_e.jump;
  assign alusrc_E     = r_e.alusrc;
  assign alucontrol_E = r_e.alucontrol;
  assign memwrite_M   = r_m.memwrite;
  assign resultsrc_W  = r_w.resultsrc;
  assign regwrite_W   = r_w.regwrite;
  assign rd_W         = r_w.rd;

endmodule
